lfsr8_ptb_descrambler: RTL and testbench
========================================

# lfsr8_ptb_descrambler

Receive-side partner of the 8-bit XNOR perturbation LFSR. It takes the serial feedback-bit stream produced by the LFSR and rebuilds the transmitter's state in a shadow register. From that it recovers each injected perturbation bit (`ptb & ptb_valid`) as `received_bit XOR expected_feedback`. It self-synchronises after 8 valid bits, tracks lock quality over a sliding window, and sits between the link/capture logic and the perturbation consumer.

## Interface
Parameters:
- `WINDOW`, 64: number of valid bits per lock-quality window (≥ 8).
- `ERR_THRESH`, 16: recovered ones within one window that declare loss of lock (1..`WINDOW`).
- `CNT_W`, 16: width of the saturating perturbation counter.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `i_bit`, input, 1: received LFSR feedback bit, i.e. the transmitter's new `o_state[0]`.
- `i_bit_valid`, input, 1: `i_bit` is meaningful this cycle. The stream may have gaps.
- `o_ptb`, output, 1: recovered perturbation bit.
- `o_ptb_valid`, output, 1: one-cycle strobe qualifying `o_ptb`.
- `o_locked`, output, 1: descrambler is in the LOCKED state.
- `o_lol`, output, 1: one-cycle loss-of-lock pulse.
- `o_ptb_count`, output, `CNT_W`: saturating count of recovered ones since the last lock acquisition.
- `o_state`, output, 8: shadow LFSR state, for debug.

## Operation
- **Shadow register.**
  - Reset value is 8'b01001100, the transmitter seed.
  - Every accepted bit (`i_bit_valid=1`) updates it as `o_state <= {o_state[6:0], i_bit}`.
  - It does not change on invalid cycles.
- **Expected feedback.** `exp = ~(o_state[7]^o_state[5]^o_state[4]^o_state[3])`, computed from the state before the shift.
- **Recovered bit.** `rec = i_bit ^ exp`.
- **FSM, two states.**
  - FILL (reset state):
    - A 3-bit fill counter counts accepted bits.
    - `o_ptb_valid` stays 0.
    - On the 8th accepted bit, the counter clears and the FSM moves to LOCKED.
  - LOCKED:
    - Every accepted bit drives `o_ptb <= rec` and `o_ptb_valid <= 1`.
    - `o_ptb_count` increments by `rec` and saturates at all-ones.
- **Lock quality (LOCKED only).**
  - A window counter counts accepted bits; an error counter counts `rec=1`.
  - If the error count reaches `ERR_THRESH`:
    - pulse `o_lol` for one cycle;
    - go to FILL and clear the fill, window and error counters;
    - the bit that triggered it still produces its `o_ptb`/`o_ptb_valid`.
  - When the window counter reaches `WINDOW`, both window and error counters clear.
  - If the threshold hit and the window end fall on the same bit, loss of lock wins.
- **On entering LOCKED:** `o_ptb_count`, the window counter and the error counter all clear.
- **Shadow shifting.** The shadow register keeps shifting in FILL, so re-synchronisation needs only 8 more valid bits.

## Timing
- **Reset values:**
  - `o_state` = 8'h4C
  - `o_ptb` = 0, `o_ptb_valid` = 0
  - `o_locked` = 0, `o_lol` = 0
  - `o_ptb_count` = 0
  - FSM = FILL
- **Latency.** Outputs are registered. `o_ptb`/`o_ptb_valid` appear 1 cycle after the accepted `i_bit`.
- **Acquisition.**
  - `o_locked` rises in the cycle after the 8th accepted bit.
  - The 9th accepted bit is the first one decoded.
- **Invalid cycles.** `o_ptb_valid=0` and no state changes. `o_ptb` holds its last value.
- **Loss of lock.** `o_lol` and the falling edge of `o_locked` appear together, 1 cycle after the offending bit.
- **Reset mid-operation.** Asynchronous return to all reset values at once, with no final strobe.
- **Counter width.** `o_ptb_count` never wraps; it stays at 2^`CNT_W`−1.

## Structure
- **Package `lfsr8_pkg`**, shared with the transmitter:
  - `LFSR8_SEED` = 8'b01001100
  - tap indices {7,5,4,3}
  - function `lfsr8_fb(state)` returning the XNOR feedback
  - FSM enum `{FILL, LOCKED}`
- **Sub-module.** One natural sub-module, `lfsr8_lock_mon`: window and error counters with threshold compare, producing `lol`.
- **Top.** The descrambler top holds the shadow register, the FSM, the fill counter and the output registers.

## Test plan
1. **Reset.** Assert `rst_n=0` mid-stream → all outputs take reset values immediately and `o_state`=8'h4C.
2. **Clean aligned stream.** Drive the transmitter output with `i_ptb_valid=0` for 200 cycles → `o_locked` rises after 8 valid bits, every `o_ptb`=0, `o_ptb_count`=0, `o_lol` never asserts.
3. **Single perturbation.** Inject `ptb=1` on transmitter cycle 40 → exactly one `o_ptb`=1, on the strobe for that bit 1 cycle later, and `o_ptb_count`=1.
4. **Mid-stream start with gaps.** Connect at an arbitrary transmitter cycle and toggle `i_bit_valid` at random → lock after exactly 8 valid bits. Decoded bits then match the injected pattern and there are no strobes on invalid cycles.
5. **Random noise.** Drive random `i_bit` with `ERR_THRESH`=16 and `WINDOW`=64 → `o_lol` pulses when the 16th recovered one lands inside a window and `o_locked` drops. Also cover the 16th one landing on the 64th bit → loss of lock still fires.
6. **Saturation.** With `CNT_W`=4, inject 20 perturbations within threshold limits → `o_ptb_count` stops at 15.

Source files
------------

// File: rtl/lfsr8_pkg.sv
// lfsr8_pkg
// Shared definitions for the 8-bit XNOR perturbation LFSR pair
// (transmitter and descrambler).
//   LFSR8_SEED      : power-on state of both ends
//   LFSR8_TAP_MASK  : feedback taps {7,5,4,3}
//   lfsr8_fb()      : XNOR feedback of a given state
//   lfsr8_fsm_e     : descrambler FSM states
package lfsr8_pkg;

  localparam logic [7:0] LFSR8_SEED     = 8'b0100_1100;
  localparam logic [7:0] LFSR8_TAP_MASK = 8'b1011_1000;

  typedef enum logic {
    FILL   = 1'b0,
    LOCKED = 1'b1
  } lfsr8_fsm_e;

  // XNOR of the tapped bits; the new bit shifted in at position 0.
  function automatic logic lfsr8_fb(input logic [7:0] state);
    return ~(^(state & LFSR8_TAP_MASK));
  endfunction

endpackage

// File: rtl/lfsr8_lock_mon.sv
// lfsr8_lock_mon
// Lock-quality monitor: counts decoded bits in a sliding window of WINDOW
// bits and the recovered ones inside it; flags loss of lock when the
// ERR_THRESH-th one of a window arrives.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear of both counters (lock acquisition)
//   bit_en     : a decoded bit is being accepted this cycle
//   rec        : recovered perturbation bit for that accepted bit
//   lol        : combinational loss-of-lock indication for this bit
module lfsr8_lock_mon #(
  parameter int WINDOW     = 64,
  parameter int ERR_THRESH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic bit_en,
  input  logic rec,
  output logic lol
);

  localparam int WIN_W = $clog2(WINDOW);
  localparam int ERR_W = $clog2(ERR_THRESH + 1);

  logic [WIN_W-1:0] win_cnt;
  logic [ERR_W-1:0] err_cnt;
  logic             win_end;

  // Counters hold the count before the current bit, so the threshold is hit
  // when one more recovered one arrives on top of ERR_THRESH-1.
  assign lol     = bit_en && rec && (err_cnt == ERR_W'(ERR_THRESH - 1));
  assign win_end = (win_cnt == WIN_W'(WINDOW - 1));

  // Loss of lock and window end both clear, so a coincidence of the two
  // still reports lol (lol does not depend on win_end).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
      err_cnt <= '0;
    end else if (clr || (bit_en && (lol || win_end))) begin
      win_cnt <= '0;
      err_cnt <= '0;
    end else if (bit_en) begin
      win_cnt <= win_cnt + 1'b1;
      err_cnt <= err_cnt + ERR_W'(rec);
    end
  end

endmodule

// File: rtl/lfsr8_ptb_descrambler.sv
// lfsr8_ptb_descrambler
// Rebuilds the transmitter LFSR state from its serial feedback stream and
// recovers injected perturbation bits as received_bit ^ expected_feedback.
// Self-synchronises after 8 valid bits; drops lock on too many ones per window.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   i_bit         : received feedback bit (transmitter's new state[0])
//   i_bit_valid   : i_bit is meaningful this cycle
//   o_ptb         : recovered perturbation bit (holds between strobes)
//   o_ptb_valid   : one-cycle strobe qualifying o_ptb
//   o_locked      : FSM is in LOCKED
//   o_lol         : one-cycle loss-of-lock pulse
//   o_ptb_count   : saturating count of recovered ones since lock acquisition
//   o_state       : shadow LFSR state (debug)
//
// state  | meaning
// FILL   | loading shadow register; counts 8 accepted bits, no decode
// LOCKED | shadow tracks transmitter; every accepted bit is decoded
module lfsr8_ptb_descrambler #(
  parameter int WINDOW     = 64,
  parameter int ERR_THRESH = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_bit,
  input  logic             i_bit_valid,
  output logic             o_ptb,
  output logic             o_ptb_valid,
  output logic             o_locked,
  output logic             o_lol,
  output logic [CNT_W-1:0] o_ptb_count,
  output logic [7:0]       o_state
);

  import lfsr8_pkg::*;

  lfsr8_fsm_e state_q;
  lfsr8_fsm_e state_d;
  logic [2:0] fill_cnt;
  logic       exp_fb;
  logic       rec;
  logic       lol;
  logic       fill_inc;
  logic       enter_locked;
  logic       decode;

  assign exp_fb = lfsr8_fb(o_state);
  assign rec    = i_bit ^ exp_fb;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FILL;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (i_bit_valid && (fill_cnt == 3'd7)) state_d = LOCKED;
      LOCKED:  if (lol) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Output/control decode
  always_comb begin
    fill_inc     = 1'b0;
    enter_locked = 1'b0;
    decode       = 1'b0;
    case (state_q)
      FILL: begin
        fill_inc     = i_bit_valid;
        enter_locked = i_bit_valid && (fill_cnt == 3'd7);
      end
      LOCKED:  decode = i_bit_valid;
      default: ;
    endcase
  end

  assign o_locked = (state_q == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     fill_cnt <= '0;
    else if (lol || enter_locked)   fill_cnt <= '0;
    else if (fill_inc)              fill_cnt <= fill_cnt + 1'b1;
  end

  // Shadow register keeps shifting in both states so a relock needs only
  // eight fresh bits after a loss of lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           o_state <= LFSR8_SEED;
    else if (i_bit_valid) o_state <= {o_state[6:0], i_bit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ptb       <= 1'b0;
      o_ptb_valid <= 1'b0;
      o_lol       <= 1'b0;
      o_ptb_count <= '0;
    end else begin
      o_ptb_valid <= decode;
      o_lol       <= lol;
      if (decode) o_ptb <= rec;
      if (enter_locked)
        o_ptb_count <= '0;
      else if (decode && rec && (o_ptb_count != {CNT_W{1'b1}}))
        o_ptb_count <= o_ptb_count + 1'b1;
    end
  end

  lfsr8_lock_mon #(
    .WINDOW     (WINDOW),
    .ERR_THRESH (ERR_THRESH)
  ) u_lock_mon (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (enter_locked),
    .bit_en (decode),
    .rec    (rec),
    .lol    (lol)
  );

endmodule

// File: tb/tb_lfsr8_ptb_descrambler.sv
module tb_lfsr8_ptb_descrambler;

  localparam int WINDOW     = 64;
  localparam int ERR_THRESH = 16;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_bit = 1'b0;
  logic             i_bit_valid = 1'b0;
  logic             o_ptb;
  logic             o_ptb_valid;
  logic             o_locked;
  logic             o_lol;
  logic [CNT_W-1:0] o_ptb_count;
  logic [7:0]       o_state;

  lfsr8_ptb_descrambler #(
    .WINDOW     (WINDOW),
    .ERR_THRESH (ERR_THRESH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_bit       (i_bit),
    .i_bit_valid (i_bit_valid),
    .o_ptb       (o_ptb),
    .o_ptb_valid (o_ptb_valid),
    .o_locked    (o_locked),
    .o_lol       (o_lol),
    .o_ptb_count (o_ptb_count),
    .o_state     (o_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: history of received bits (oldest first), acquisition and
  // window bookkeeping as plain integers.
  bit   m_hist[$];
  int   m_nvalid, m_win, m_err, m_cnt, m_lol_total;
  bit   m_locked, m_ptb, m_pv, m_lol;
  logic [7:0] seed = 8'h4C;
  logic [7:0] tx_state;
  int   lol_seen, ones_seen;

  typedef struct {
    bit         v;
    bit         b;
    logic [7:0] st;
    bit         lk;
    bit         pv;
    bit         ptb;
    int         cnt;
  } vec_t;
  vec_t tbl[14];

  function void check1(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function void model_reset();
    m_hist.delete();
    for (int i = 7; i >= 0; i--) m_hist.push_back(seed[i]);
    m_nvalid = 0; m_win = 0; m_err = 0; m_cnt = 0;
    m_locked = 0; m_ptb = 0; m_pv = 0; m_lol = 0;
  endfunction

  function logic [7:0] model_state();
    logic [7:0] s;
    for (int i = 0; i < 8; i++) s[7-i] = m_hist[i];
    return s;
  endfunction

  function void model_step(input bit v, input bit b);
    bit e, r;
    m_pv = 0; m_lol = 0;
    if (!v) return;
    // expected feedback from the bits received 8, 6, 5 and 4 steps ago
    e = 1'b1 ^ m_hist[0] ^ m_hist[2] ^ m_hist[3] ^ m_hist[4];
    r = b ^ e;
    void'(m_hist.pop_front());
    m_hist.push_back(b);
    if (!m_locked) begin
      m_nvalid++;
      if (m_nvalid == 8) begin
        m_locked = 1; m_nvalid = 0; m_cnt = 0; m_win = 0; m_err = 0;
      end
    end else begin
      m_pv = 1; m_ptb = r;
      if (r && m_cnt < CNT_MAX) m_cnt++;
      m_win++;
      m_err += int'(r);
      if (m_err == ERR_THRESH) begin
        m_lol = 1; m_locked = 0; m_nvalid = 0; m_win = 0; m_err = 0;
        m_lol_total++;
      end else if (m_win == WINDOW) begin
        m_win = 0; m_err = 0;
      end
    end
  endfunction

  function void check_all();
    check1("state", int'(o_state), int'(model_state()));
    check1("ptb_valid", int'(o_ptb_valid), int'(m_pv));
    check1("ptb", int'(o_ptb), int'(m_ptb));
    check1("locked", int'(o_locked), int'(m_locked));
    check1("lol", int'(o_lol), int'(m_lol));
    check1("ptb_count", int'(o_ptb_count), m_cnt);
  endfunction

  task automatic cycle(input bit v, input bit b, input int inj);
    @(negedge clk);
    i_bit_valid = v;
    i_bit = b;
    model_step(v, b);
    @(posedge clk);
    #1;
    check_all();
    if (o_lol) lol_seen++;
    if (o_ptb_valid && o_ptb) ones_seen++;
    if (inj >= 0 && m_pv) check1("decoded_vs_injected", int'(o_ptb), inj);
  endtask

  // Transmitter: new bit = XNOR feedback ^ perturbation, advances only when sent.
  task automatic tx_send(input bit v, input bit ptb);
    bit fb, b;
    if (v) begin
      fb = ~(tx_state[7] ^ tx_state[5] ^ tx_state[4] ^ tx_state[3]);
      b  = fb ^ ptb;
      tx_state = {tx_state[6:0], b};
      cycle(1'b1, b, int'(ptb));
    end else begin
      cycle(1'b0, 1'($urandom_range(0, 1)), -1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    i_bit_valid = 1'b0;
    model_reset();
    tx_state = seed;
    lol_seen = 0; ones_seen = 0; m_lol_total = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt;
    bit seen_lock;

    // clean seed stream: bits 0,0,1,0,0,0,0,0,0 then a perturbed bit
    tbl[0]  = '{1, 0, 8'h98, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 8'h98, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 8'h30, 0, 0, 0, 0};
    tbl[3]  = '{1, 1, 8'h61, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 8'hC2, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 8'hC2, 0, 0, 0, 0};
    tbl[6]  = '{1, 0, 8'h84, 0, 0, 0, 0};
    tbl[7]  = '{1, 0, 8'h08, 0, 0, 0, 0};
    tbl[8]  = '{1, 0, 8'h10, 0, 0, 0, 0};
    tbl[9]  = '{1, 0, 8'h20, 1, 0, 0, 0};
    tbl[10] = '{1, 0, 8'h40, 1, 1, 0, 0};
    tbl[11] = '{0, 1, 8'h40, 1, 0, 0, 0};
    tbl[12] = '{1, 0, 8'h80, 1, 1, 1, 1};
    tbl[13] = '{1, 0, 8'h00, 1, 1, 0, 1};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      i_bit_valid = tbl[i].v;
      i_bit = tbl[i].b;
      @(posedge clk);
      #1;
      check1("tbl_state", int'(o_state), int'(tbl[i].st));
      check1("tbl_locked", int'(o_locked), int'(tbl[i].lk));
      check1("tbl_ptb_valid", int'(o_ptb_valid), int'(tbl[i].pv));
      check1("tbl_ptb", int'(o_ptb), int'(tbl[i].ptb));
      check1("tbl_count", int'(o_ptb_count), tbl[i].cnt);
      check1("tbl_lol", int'(o_lol), 0);
    end

    // clean aligned stream
    do_reset();
    for (int c = 0; c < 200; c++) tx_send(1'b1, 1'b0);
    check1("clean_ones", ones_seen, 0);
    check1("clean_lol", lol_seen, 0);
    check1("clean_locked", int'(o_locked), 1);
    check1("clean_count", int'(o_ptb_count), 0);

    // single perturbation on transmitter cycle 40
    do_reset();
    for (int c = 1; c <= 100; c++) begin
      tx_send(1'b1, c == 40);
      if (c == 40) begin
        check1("single_strobe", int'(o_ptb_valid && o_ptb), 1);
      end
    end
    check1("single_ones", ones_seen, 1);
    check1("single_count", int'(o_ptb_count), 1);

    // asynchronous reset mid-stream
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check1("rst_state", int'(o_state), 8'h4C);
    check1("rst_ptb", int'(o_ptb), 0);
    check1("rst_ptb_valid", int'(o_ptb_valid), 0);
    check1("rst_locked", int'(o_locked), 0);
    check1("rst_lol", int'(o_lol), 0);
    check1("rst_count", int'(o_ptb_count), 0);

    // mid-stream start with gaps
    do_reset();
    for (int k = 0; k < int'($urandom_range(1, 300)); k++)
      tx_state = {tx_state[6:0], ~(tx_state[7] ^ tx_state[5] ^ tx_state[4] ^ tx_state[3])};
    vcnt = 0;
    seen_lock = 0;
    for (int c = 0; c < 300; c++) begin
      bit v;
      v = 1'($urandom_range(0, 1));
      tx_send(v, $urandom_range(0, 9) == 0);
      if (!o_ptb_valid) check1("gap_no_strobe_when_idle", int'(o_ptb_valid && !v), 0);
      if (v && !seen_lock) vcnt++;
      if (o_locked && !seen_lock) begin
        seen_lock = 1;
        check1("lock_after_valid", vcnt, 8);
      end
    end
    check1("gap_locked_seen", int'(seen_lock), 1);

    // random noise
    do_reset();
    for (int c = 0; c < 400; c++)
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), -1);
    check1("noise_lol_count", lol_seen, m_lol_total);
    check1("noise_lol_nonzero", int'(lol_seen > 0), 1);

    // 16th one on the 64th bit of the window
    do_reset();
    for (int c = 0; c < 8; c++) tx_send(1'b1, 1'b0);
    for (int c = 0; c < 48; c++) tx_send(1'b1, 1'b0);
    for (int c = 0; c < 15; c++) tx_send(1'b1, 1'b1);
    check1("edge_pre_locked", int'(o_locked), 1);
    tx_send(1'b1, 1'b1);
    check1("edge_lol", int'(o_lol), 1);
    check1("edge_unlocked", int'(o_locked), 0);
    check1("edge_last_strobe", int'(o_ptb_valid && o_ptb), 1);

    // 15 ones end a window, 15 more in the next must not trip, the 16th does
    do_reset();
    for (int c = 0; c < 8; c++) tx_send(1'b1, 1'b0);
    for (int c = 0; c < 49; c++) tx_send(1'b1, 1'b0);
    for (int c = 0; c < 30; c++) tx_send(1'b1, 1'b1);
    check1("xwin_still_locked", int'(o_locked), 1);
    check1("xwin_no_lol", lol_seen, 0);
    tx_send(1'b1, 1'b1);
    check1("xwin_lol", int'(o_lol), 1);
    for (int c = 0; c < 20; c++) tx_send(1'b1, 1'b0);
    check1("xwin_relocked", int'(o_locked), 1);

    // saturation of the 4-bit counter
    do_reset();
    for (int c = 0; c < 8; c++) tx_send(1'b1, 1'b0);
    for (int c = 0; c < 160; c++) tx_send(1'b1, (c % 8) == 3);
    check1("sat_ones", ones_seen, 20);
    check1("sat_count", int'(o_ptb_count), 15);
    check1("sat_no_lol", lol_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
